// File: rtl/dsm_din_fifo_pkg.sv
// Shared constants for the delta-sigma din sample FIFO: register addresses,
// field positions and the CTRL readback packer.
package dsm_din_fifo_pkg;

    localparam logic [31:0] ADDR_CTRL   = 32'd0;
    localparam logic [31:0] ADDR_DATA   = 32'd1;
    localparam logic [31:0] ADDR_STATUS = 32'd2;

    localparam int unsigned CTRL_DMA_BIT = 0;
    localparam int unsigned CTRL_IRQ_BIT = 1;
    localparam int unsigned CTRL_WM_LSB  = 8;
    localparam int unsigned CTRL_WM_W    = 8;
    localparam int unsigned FLUSH_BIT    = 31;

    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_UDF_BIT   = 3;
    localparam int unsigned STAT_COUNT_LSB = 16;

    function automatic logic [31:0] ctrl_word(logic dma_mode, logic irq_en,
                                              logic [CTRL_WM_W-1:0] wm);
        logic [31:0] w;
        w = '0;
        w[CTRL_DMA_BIT] = dma_mode;
        w[CTRL_IRQ_BIT] = irq_en;
        w[CTRL_WM_LSB +: CTRL_WM_W] = wm;
        return w;
    endfunction

endpackage

// File: rtl/dsm_din_fifo_if.sv
// Register bus plus modulator-facing outputs of the din sample FIFO.
interface dsm_din_fifo_if;
    logic        we;
    logic        sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] dout;
    logic        dma_req;
    logic        irq;

    modport master (output we, sel, addr, wdata, input rdata, dout, dma_req, irq);
    modport slave  (input we, sel, addr, wdata, output rdata, dout, dma_req, irq);
endinterface

// File: rtl/dsm_din_fifo_ck_edge_sync.sv
// ck_edge_sync: 2-flop synchroniser plus 1-clk rising-edge pulse for an async
// clock-level input; the first edges after reset are masked until history is valid.
module ck_edge_sync (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_rise
);
    logic       r_s1, r_s2, r_hist;
    logic [2:0] r_prime;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_hist  <= 1'b0;
            r_prime <= 3'b000;
        end else begin
            r_s1    <= i_d;
            r_s2    <= r_s1;
            r_hist  <= r_s2;
            r_prime <= {r_prime[1:0], 1'b1};
        end
    end

    // A level already high at reset release must not look like an edge.
    assign o_rise = r_s2 & ~r_hist & r_prime[2];
endmodule

// File: rtl/dsm_din_fifo.sv
// Sample FIFO feeding the delta-sigma modulator din; one pop per uck rising edge.
// Optional interrupt output built when DSM_DIN_FIFO_IRQ_EN is defined.
module dsm_din_fifo
    import dsm_din_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_enable,
    input  logic i_uck,
    dsm_din_fifo_if.slave bus
);
    logic [31:0]    r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [AW:0]    r_count;
    logic [31:0]    r_dout;
    logic           r_ovf, r_udf, r_dma_mode, r_dma_req;
    logic [7:0]     r_wmark;
    logic [31:0]    w_rdata;
    logic           w_irq_en, w_pop_stb;

    ck_edge_sync u_uck_sync (
        .clk    (clk),
        .rstn   (rstn),
        .i_d    (i_uck),
        .o_rise (w_pop_stb)
    );

    logic w_empty, w_full, w_wr, w_push, w_ctrl_wr, w_stat_wr, w_flush;
    logic w_pop, w_do_pop, w_do_push, w_count_le_wm;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_wr      = bus.we & bus.sel;
    assign w_push    = w_wr & (bus.addr == ADDR_DATA);
    assign w_ctrl_wr = w_wr & (bus.addr == ADDR_CTRL);
    assign w_stat_wr = w_wr & (bus.addr == ADDR_STATUS);
    assign w_flush   = w_ctrl_wr & bus.wdata[FLUSH_BIT];
    assign w_pop     = w_pop_stb & i_enable;
    assign w_do_pop  = w_pop & ~w_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_do_push = w_push & (~w_full | w_do_pop);
    assign w_count_le_wm = {{(31-AW){1'b0}}, r_count} <= {24'b0, r_wmark};

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= bus.wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_dout     <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_dma_mode <= 1'b0;
            r_wmark    <= '0;
            r_dma_req  <= 1'b0;
        end else begin
            if (w_do_pop) r_dout <= r_mem[r_rd_ptr];
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
            end
            // Set events win over a simultaneous W1C.
            r_ovf <= (w_push & ~w_do_push) | (r_ovf & ~(w_stat_wr & bus.wdata[STAT_OVF_BIT]));
            r_udf <= (w_pop & w_empty) | (r_udf & ~(w_stat_wr & bus.wdata[STAT_UDF_BIT]));
            if (w_ctrl_wr) begin
                r_dma_mode <= bus.wdata[CTRL_DMA_BIT];
                r_wmark    <= bus.wdata[CTRL_WM_LSB +: CTRL_WM_W];
            end
            r_dma_req <= r_dma_mode & w_count_le_wm;
        end
    end

`ifdef DSM_DIN_FIFO_IRQ_EN
    logic r_irq_en, r_irq;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= bus.wdata[CTRL_IRQ_BIT];
            r_irq <= r_irq_en & (r_ovf | r_udf | w_count_le_wm);
        end
    end
    assign w_irq_en = r_irq_en;
    assign bus.irq  = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign bus.irq  = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (bus.sel) begin
            case (bus.addr)
                ADDR_CTRL:   w_rdata = ctrl_word(r_dma_mode, w_irq_en, r_wmark);
                ADDR_DATA:   w_rdata = r_dout;
                ADDR_STATUS: begin
                    w_rdata[STAT_EMPTY_BIT] = w_empty;
                    w_rdata[STAT_FULL_BIT]  = w_full;
                    w_rdata[STAT_OVF_BIT]   = r_ovf;
                    w_rdata[STAT_UDF_BIT]   = r_udf;
                    w_rdata[STAT_COUNT_LSB +: AW+1] = r_count;
                end
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.rdata   = w_rdata;
    assign bus.dout    = r_dout;
    assign bus.dma_req = r_dma_req;
endmodule
